// File: rtl/ps_if_regfile_if.sv
// ps_if request/response bus between the response copier and register-bank endpoints.
interface ps_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] waddr;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  wvalid;
   logic                  wready;
   logic                  wresp;
   logic [ADDR_WIDTH-1:0] raddr;
   logic                  arvalid;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  rvalid;
   logic                  rready;

   modport slave (
      input  waddr, wdata, wvalid, raddr, arvalid, rready,
      output wready, wresp, rdata, rvalid
   );

   modport master (
      output waddr, wdata, wvalid, raddr, arvalid, rready,
      input  wready, wresp, rdata, rvalid
   );
endinterface

// File: rtl/ps_if_regfile.sv
// Register-bank endpoint on ps_if: fixed-latency read pipeline feeding an in-order
// response FIFO, with credit-limited reads and a saturating error counter.
module ps_if_regfile #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 8,
   parameter int NUM_REGS     = 16,
   parameter int READ_LATENCY = 2,
   parameter int RESP_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        rst,
   ps_if.slave         s,
   input  logic        clr_err,
   output logic [15:0] err_cnt,
   output logic        rd_overflow
);
   localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
   localparam int CNT_W = $clog2(RESP_DEPTH + 1);
   localparam logic [ADDR_WIDTH:0] NUM_REGS_EXT = (ADDR_WIDTH + 1)'(NUM_REGS);

   logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
   logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];
   logic                    wready_q, wready_d;
   logic                    wresp_q, wresp_d;
   logic [READ_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
   logic [DATA_WIDTH-1:0]   pipe_dat_q [READ_LATENCY];
   logic [DATA_WIDTH-1:0]   pipe_dat_d [READ_LATENCY];
   logic [DATA_WIDTH-1:0]   fifo_mem_q [RESP_DEPTH];
   logic [DATA_WIDTH-1:0]   fifo_mem_d [RESP_DEPTH];
   logic [PTR_W-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CNT_W-1:0]        fifo_cnt_q, fifo_cnt_d;
   logic [CNT_W-1:0]        outstanding_q, outstanding_d;
   logic [15:0]             err_cnt_q, err_cnt_d;
   logic                    rd_overflow_q, rd_overflow_d;

   logic                  wr_accept, wr_in_range, rd_in_range, rd_accept, rd_drop;
   logic                  fifo_push, fifo_pop, fifo_full, rvalid;
   logic [DATA_WIDTH-1:0] rd_sample;
   logic [1:0]            err_inc;
   logic [16:0]           err_sum;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Read credit is counted from accept until the requester consumes the data,
   // so the pipeline plus FIFO can never hold more than RESP_DEPTH entries.
   always_comb begin
      wr_in_range = {1'b0, s.waddr} < NUM_REGS_EXT;
      rd_in_range = {1'b0, s.raddr} < NUM_REGS_EXT;
      wr_accept   = s.wvalid && wready_q;
      rd_accept   = s.arvalid && (outstanding_q < CNT_W'(RESP_DEPTH));
      rd_drop     = s.arvalid && !rd_accept;
      rd_sample   = rd_in_range ? regs_q[s.raddr[IDX_W-1:0]] : '0;
      rvalid      = fifo_cnt_q != '0;
      fifo_push   = pipe_vld_q[READ_LATENCY-1];
      fifo_pop    = rvalid && s.rready;
      fifo_full   = fifo_cnt_q == CNT_W'(RESP_DEPTH);
   end

   always_comb begin
      regs_d   = regs_q;
      wready_d = 1'b1;
      wresp_d  = wr_accept;
      if (wr_accept && wr_in_range) begin
         regs_d[s.waddr[IDX_W-1:0]] = s.wdata;
      end
   end

   always_comb begin
      pipe_vld_d    = '0;
      pipe_dat_d    = pipe_dat_q;
      pipe_vld_d[0] = rd_accept;
      pipe_dat_d[0] = rd_sample;
      for (int i = 1; i < READ_LATENCY; i++) begin
         pipe_vld_d[i] = pipe_vld_q[i-1];
         pipe_dat_d[i] = pipe_dat_q[i-1];
      end
   end

   always_comb begin
      fifo_mem_d    = fifo_mem_q;
      wptr_d        = wptr_q;
      rptr_d        = rptr_q;
      fifo_cnt_d    = fifo_cnt_q + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
      outstanding_d = outstanding_q + CNT_W'(rd_accept) - CNT_W'(fifo_pop);
      if (fifo_push) begin
         fifo_mem_d[wptr_q] = pipe_dat_q[READ_LATENCY-1];
         wptr_d             = ptr_inc(wptr_q);
      end
      if (fifo_pop) begin
         rptr_d = ptr_inc(rptr_q);
      end
   end

   // A bad write and a bad or dropped read can land on the same edge, hence up to +2.
   always_comb begin
      err_inc = {1'b0, wr_accept && !wr_in_range}
              + {1'b0, rd_accept && !rd_in_range}
              + {1'b0, rd_drop};
      err_sum = {1'b0, err_cnt_q} + 17'(err_inc);
      if (clr_err) begin
         err_cnt_d     = '0;
         rd_overflow_d = 1'b0;
      end else begin
         err_cnt_d     = err_sum[16] ? 16'hFFFF : err_sum[15:0];
         rd_overflow_d = rd_overflow_q || rd_drop;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         regs_q        <= '{default: '0};
         wready_q      <= 1'b0;
         wresp_q       <= 1'b0;
         pipe_vld_q    <= '0;
         wptr_q        <= '0;
         rptr_q        <= '0;
         fifo_cnt_q    <= '0;
         outstanding_q <= '0;
         err_cnt_q     <= '0;
         rd_overflow_q <= 1'b0;
      end else begin
         regs_q        <= regs_d;
         wready_q      <= wready_d;
         wresp_q       <= wresp_d;
         pipe_vld_q    <= pipe_vld_d;
         wptr_q        <= wptr_d;
         rptr_q        <= rptr_d;
         fifo_cnt_q    <= fifo_cnt_d;
         outstanding_q <= outstanding_d;
         err_cnt_q     <= err_cnt_d;
         rd_overflow_q <= rd_overflow_d;
      end
   end

   always_ff @(posedge clk) begin
      pipe_dat_q <= pipe_dat_d;
      fifo_mem_q <= fifo_mem_d;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(fifo_push && fifo_full));
      end
   end

   assign s.wready    = wready_q;
   assign s.wresp     = wresp_q;
   assign s.rvalid    = rvalid;
   assign s.rdata     = rvalid ? fifo_mem_q[rptr_q] : '0;
   assign err_cnt     = err_cnt_q;
   assign rd_overflow = rd_overflow_q;
endmodule
